// File: rtl/lsu_request_sequencer_if.sv
// CPU request/response and load_store memory bus for the LSU sequencer.
// master = CPU/memory side, slave = the sequencer itself.
interface lsu_request_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exception;
    logic [3:0]  rsp_cause;

    logic        mem_en;
    logic        mem_wr;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_exception;

    modport master (
        output req_valid,
        output req_wr,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output mem_rdata,
        output mem_exception,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_exception,
        input  rsp_cause,
        input  mem_en,
        input  mem_wr,
        input  mem_size,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  req_valid,
        input  req_wr,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  mem_rdata,
        input  mem_exception,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_exception,
        output rsp_cause,
        output mem_en,
        output mem_wr,
        output mem_size,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/lsu_request_sequencer.sv
// One-at-a-time load/store sequencer: precheck, memory enable timing,
// load data extension and a registered single-cycle response.
module lsu_request_sequencer #(
    parameter int READ_LATENCY = 1
) (
    input logic                     CLK,
    input logic                     reset,
    lsu_request_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

    state_t      state;
    state_t      state_n;
    logic [2:0]  cnt;
    logic [2:0]  cnt_n;

    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        rsp_v_q;
    logic        rsp_e_q;
    logic [3:0]  rsp_c_q;
    logic [31:0] rsp_d_q;
    logic        rsp_v_n;
    logic        rsp_e_n;
    logic [3:0]  rsp_c_n;
    logic [31:0] rsp_d_n;

    logic        accept;
    logic        is_half;
    logic        is_word;
    logic        misal;
    logic        legal_f3;
    logic        fault;
    logic [7:0]  region;
    logic [31:0] ext_data;

    assign accept = bus.req_valid && (state == IDLE);
    assign region = bus.req_addr[31:24];

    // Precheck on the live request; only meaningful in the accept cycle.
    always_comb begin
        is_half  = (bus.req_funct3 == 3'b001)
                || (bus.req_funct3 == 3'b101);
        is_word  = (bus.req_funct3 == 3'b010);
        misal    = (is_half && bus.req_addr[0])
                || (is_word && (bus.req_addr[1:0] != 2'b00));
        legal_f3 = 1'b0;
        unique case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = !bus.req_wr;
            default:                legal_f3 = 1'b0;
        endcase
        fault = !legal_f3
             || (region > 8'h02)
             || (bus.req_wr && (region == 8'h00));
    end

    always_comb begin
        ext_data = bus.mem_rdata;
        unique case (f3_q)
            3'b000:  ext_data = {{24{bus.mem_rdata[7]}},
                                 bus.mem_rdata[7:0]};
            3'b100:  ext_data = {24'd0, bus.mem_rdata[7:0]};
            3'b001:  ext_data = {{16{bus.mem_rdata[15]}},
                                 bus.mem_rdata[15:0]};
            3'b101:  ext_data = {16'd0, bus.mem_rdata[15:0]};
            default: ext_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rsp_v_n = 1'b0;
        rsp_e_n = 1'b0;
        rsp_c_n = 4'd0;
        rsp_d_n = 32'd0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (misal) begin
                        state_n = RESP;
                        rsp_v_n = 1'b1;
                        rsp_e_n = 1'b1;
                        rsp_c_n = bus.req_wr ? 4'd6 : 4'd4;
                    end else if (fault) begin
                        state_n = RESP;
                        rsp_v_n = 1'b1;
                        rsp_e_n = 1'b1;
                        rsp_c_n = bus.req_wr ? 4'd7 : 4'd5;
                    end else begin
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_n = RESP;
                    rsp_v_n = 1'b1;
                end else begin
                    state_n = WAIT;
                    cnt_n   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_n = RESP;
                    rsp_v_n = 1'b1;
                    if (bus.mem_exception) begin
                        rsp_e_n = 1'b1;
                        rsp_c_n = 4'd5;
                    end else begin
                        rsp_d_n = ext_data;
                    end
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            wr_q    <= bus.req_wr;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rsp_v_q <= 1'b0;
            rsp_e_q <= 1'b0;
            rsp_c_q <= 4'd0;
            rsp_d_q <= 32'd0;
        end else begin
            rsp_v_q <= rsp_v_n;
            rsp_e_q <= rsp_e_n;
            rsp_c_q <= rsp_c_n;
            rsp_d_q <= rsp_d_n;
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.rsp_valid     = rsp_v_q;
    assign bus.rsp_exception = rsp_e_q;
    assign bus.rsp_cause     = rsp_c_q;
    assign bus.rsp_rdata     = rsp_d_q;

    // Enable is decoded from state so reset drops it without a clock.
    assign bus.mem_en    = (state == ISSUE) || (state == WAIT);
    assign bus.mem_wr    = (state == ISSUE) && wr_q;
    assign bus.mem_size  = f3_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_request_sequencer.sv
// Bench for lsu_request_sequencer: directed table, reset corner case
// and randomized requests against a behavioural model.
module tb_lsu_request_sequencer;

    localparam int RL = 1;

    logic CLK;
    logic reset;

    lsu_request_sequencer_if bus ();

    lsu_request_sequencer #(
        .READ_LATENCY(RL)
    ) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass;
    int n_total;

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mexc;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] data;
        int          lat;
        int          en;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void model(
        input  logic        wr,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] rd,
        input  logic        mexc,
        output logic        exc,
        output logic [3:0]  cause,
        output logic [31:0] data,
        output int          lat,
        output int          en
    );
        int     size;
        int     region;
        bit     legal;
        bit     misal;
        bit     bad;
        longint v;
        legal  = wr ? (f3 <= 3'd2) : (f3 inside {0, 1, 2, 4, 5});
        size   = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 1;
        misal  = (addr % size) != 0;
        region = int'(addr >> 24);
        bad    = !legal || region > 2 || (wr && region == 0);
        exc    = 1'b0;
        cause  = 4'd0;
        data   = 32'd0;
        v      = 0;
        if (misal) begin
            exc = 1'b1; cause = wr ? 4'd6 : 4'd4; lat = 1; en = 0;
        end else if (bad) begin
            exc = 1'b1; cause = wr ? 4'd7 : 4'd5; lat = 1; en = 0;
        end else if (wr) begin
            lat = 2; en = 1;
        end else begin
            lat = RL + 2;
            en  = RL + 1;
            if (mexc) begin
                exc = 1'b1; cause = 4'd5;
            end else begin
                case (f3)
                    3'd0: begin
                        v = rd & 255;
                        if (v >= 128) v -= 256;
                    end
                    3'd4: v = rd & 255;
                    3'd1: begin
                        v = rd & 65535;
                        if (v >= 32768) v -= 65536;
                    end
                    3'd5: v = rd & 65535;
                    default: v = rd;
                endcase
                data = v[31:0];
            end
        end
    endfunction

    task automatic do_req(input vec_t t);
        int k;
        int en_n;
        int wr_n;
        int bad;
        bit got;
        bus.mem_rdata     = t.rdata;
        bus.mem_exception = t.mexc;
        bus.req_wr        = t.wr;
        bus.req_funct3    = t.f3;
        bus.req_addr      = t.addr;
        bus.req_wdata     = t.wdata;
        bus.req_valid     = 1'b1;
        chk({t.name, ".ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge CLK); #1;
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        k = 0; en_n = 0; wr_n = 0; bad = 0; got = 1'b0;
        while (k < 20) begin
            if (bus.mem_en) begin
                en_n++;
                if (bus.mem_wr) wr_n++;
                if (bus.mem_addr !== t.addr || bus.mem_size !== t.f3)
                    bad++;
                if (t.wr && bus.mem_wdata !== t.wdata) bad++;
            end
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge CLK); #1;
            k++;
        end
        chk({t.name, ".rsp_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({t.name, ".lat"}, 32'(k + 1), 32'(t.lat));
            chk({t.name, ".exc"}, 32'(bus.rsp_exception), 32'(t.exc));
            chk({t.name, ".cause"}, 32'(bus.rsp_cause), 32'(t.cause));
            chk({t.name, ".rdata"}, bus.rsp_rdata, t.data);
            chk({t.name, ".en_cycles"}, 32'(en_n), 32'(t.en));
            chk({t.name, ".wr_cycles"}, 32'(wr_n),
                32'((t.wr && t.en == 1) ? 1 : 0));
            chk({t.name, ".bus_stable"}, 32'(bad), 32'd0);
            @(posedge CLK); #1;
            chk({t.name, ".rsp_drop"},
                {bus.rsp_rdata[30:0], bus.rsp_valid}, 32'd0);
            chk({t.name, ".idle"}, 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        vec_t r;
        int   seen;
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{"lb_neg", 0, 3'b000, 32'h0100_0003, 0,
                     32'h0000_0080, 0, 0, 0, 32'hFFFF_FF80, 3, 2};
        vecs[1]  = '{"lhu", 0, 3'b101, 32'h0100_0002, 0,
                     32'h0000_8001, 0, 0, 0, 32'h0000_8001, 3, 2};
        vecs[2]  = '{"sw_uart", 1, 3'b010, 32'h0200_0000, 32'h55,
                     0, 0, 0, 0, 0, 2, 1};
        vecs[3]  = '{"lw_misal", 0, 3'b010, 32'h0100_0006, 0,
                     0, 0, 1, 4, 0, 1, 0};
        vecs[4]  = '{"sh_rom", 1, 3'b001, 32'h0000_0010, 32'h1234,
                     0, 0, 1, 7, 0, 1, 0};
        vecs[5]  = '{"lw_unmap", 0, 3'b010, 32'h0300_0000, 0,
                     0, 0, 1, 5, 0, 1, 0};
        vecs[6]  = '{"lw_memexc", 0, 3'b010, 32'h0100_0010, 0,
                     32'hDEAD_BEEF, 1, 1, 5, 0, 3, 2};
        vecs[7]  = '{"lh_neg", 0, 3'b001, 32'h0100_0002, 0,
                     32'h1234_8001, 0, 0, 0, 32'hFFFF_8001, 3, 2};
        vecs[8]  = '{"lbu", 0, 3'b100, 32'h0100_0001, 0,
                     32'h0000_00F0, 0, 0, 0, 32'h0000_00F0, 3, 2};
        vecs[9]  = '{"lw_rom", 0, 3'b010, 32'h0000_0100, 0,
                     32'hCAFE_F00D, 0, 0, 0, 32'hCAFE_F00D, 3, 2};
        vecs[10] = '{"sh_misal", 1, 3'b001, 32'h0100_0001, 0,
                     0, 0, 1, 6, 0, 1, 0};
        vecs[11] = '{"ld_badf3", 0, 3'b011, 32'h0100_0000, 0,
                     0, 0, 1, 5, 0, 1, 0};
        vecs[12] = '{"sw_memexc", 1, 3'b010, 32'h0100_0004,
                     32'hA5A5_A5A5, 0, 1, 0, 0, 0, 2, 1};
        vecs[13] = '{"sw_misal_prio", 1, 3'b010, 32'h0000_0002, 0,
                     0, 0, 1, 6, 0, 1, 0};

        reset             = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_wr        = 1'b0;
        bus.req_funct3    = 3'd0;
        bus.req_addr      = 32'd0;
        bus.req_wdata     = 32'd0;
        bus.mem_rdata     = 32'd0;
        bus.mem_exception = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.ready", 32'(bus.req_ready), 32'd1);
        chk("rst.rsp", {bus.rsp_rdata[27:0], bus.rsp_cause},
            32'd0);
        chk("rst.flags",
            32'({bus.rsp_valid, bus.rsp_exception,
                 bus.mem_en, bus.mem_wr}), 32'd0);
        chk("rst.addr", bus.mem_addr, 32'd0);
        reset = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 14; i++) do_req(vecs[i]);

        // Reset while the load is in WAIT must kill it silently.
        bus.req_wr     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0100_0020;
        bus.req_valid  = 1'b1;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        chk("rstw.issue_en", 32'(bus.mem_en), 32'd1);
        @(posedge CLK); #1;
        chk("rstw.wait_en", 32'(bus.mem_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw.en_drop", 32'({bus.mem_en, bus.mem_wr}), 32'd0);
        chk("rstw.ready", 32'(bus.req_ready), 32'd1);
        @(posedge CLK); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid) seen++;
            @(posedge CLK); #1;
        end
        chk("rstw.no_rsp", 32'(seen), 32'd0);
        r = '{"rstw.lw_after", 0, 3'b010, 32'h0100_0040, 0,
              32'h1357_9BDF, 0, 0, 0, 32'h1357_9BDF, 3, 2};
        do_req(r);

        for (int i = 0; i < 150; i++) begin
            int          rg;
            int          f3s[8];
            f3s = '{0, 1, 2, 4, 5, 0, 1, 2};
            r.name  = $sformatf("rnd%0d", i);
            r.wr    = 1'($urandom);
            r.f3    = ($urandom_range(0, 9) == 0)
                    ? 3'($urandom) : 3'(f3s[$urandom_range(0, 7)]);
            rg      = $urandom_range(0, 4);
            if (rg == 4) rg = $urandom_range(3, 255);
            r.addr  = {8'(rg), 24'($urandom)};
            if ($urandom_range(0, 1) == 1) r.addr[1:0] = 2'b00;
            r.wdata = $urandom;
            r.rdata = $urandom;
            r.mexc  = ($urandom_range(0, 7) == 0);
            model(r.wr, r.f3, r.addr, r.rdata, r.mexc,
                  r.exc, r.cause, r.data, r.lat, r.en);
            do_req(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
